// File: rtl/hash_core_arbiter.sv
// rtl/hash_core_arbiter.sv - round-robin arbiter sharing one 32-bit hash core between byte-stream requesters
module hash_core_arbiter #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*CNT_W-1:0]     req_len,
    input  logic [N_REQ-1:0]           byte_valid,
    input  logic [N_REQ*8-1:0]         byte_data,
    output logic [N_REQ-1:0]           byte_ready,
    output logic [N_REQ-1:0]           done,
    output logic [N_REQ-1:0]           err,
    output logic [31:0]                digest_out,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       core_M_valid,
    output logic [7:0]                 core_message,
    output logic [CNT_W-1:0]           core_counter,
    input  logic                       core_accept,
    input  logic                       core_hash_ready,
    input  logic [31:0]                core_digest
);
    localparam int GW   = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_DIG, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       digest_q, digest_d;
    logic [N_REQ-1:0]  err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic [CNT_W-1:0]  len_arr  [N_REQ];
    logic [7:0]        data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign len_arr[i]  = req_len[i*CNT_W +: CNT_W];
        assign data_arr[i] = byte_data[i*8 +: 8];
    end

    // Round-robin pick: first pending requester after the last one served.
    logic          found;
    logic [GW-1:0] pick;
    logic [GW-1:0] cand;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = GW'((int'(ptr_q) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    logic hs;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        digest_d     = digest_q;
        err_d        = '0;
        wd_d         = wd_q;
        hs           = 1'b0;
        byte_ready   = '0;
        done         = '0;
        core_M_valid = 1'b0;
        core_message = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ptr_d = pick;
                    if (len_arr[pick] == '0) begin
                        err_d[pick] = 1'b1;
                    end else begin
                        grant_d = pick;
                        rem_d   = len_arr[pick];
                        cnt_d   = len_arr[pick];
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                core_M_valid        = byte_valid[grant_q];
                core_message        = data_arr[grant_q];
                hs                  = core_accept & byte_valid[grant_q];
                byte_ready[grant_q] = hs;
                if (hs) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        wd_d    = '0;
                        state_d = S_WAIT_DIG;
                    end
                end
            end
            S_WAIT_DIG: begin
                if (core_hash_ready) begin
                    digest_d = core_digest;
                    state_d  = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    err_d[grant_q] = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_DONE: begin
                done[grant_q] = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= GW'(N_REQ - 1);
            grant_q  <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            digest_q <= '0;
            err_q    <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            digest_q <= digest_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    assign err          = err_q;
    assign busy         = (state_q != S_IDLE);
    assign digest_out   = digest_q;
    assign grant_id     = grant_q;
    assign core_counter = cnt_q;

endmodule
